malu_pipe: RTL and testbench

- Parametrised, pipelined successor to the 3-bit combinational mALU.
- Implements an N-bit ALU with:
  - a 3-bit opcode;
  - registered operands and a registered result;
  - a valid handshake;
  - an internal accumulator;
  - Z, N and sticky-overflow status flags.
- Sits between the operand source (switch/register file) and result display/writeback logic. Accepts one operation per clock.

---
 rtl/malu_pipe_if.sv | 49 ++++
 rtl/malu_pipe.sv | 196 +++++++++++++++++++
 tb/tb_malu_pipe.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/malu_pipe_if.sv
// ---------------------------------------------------------------------------
// malu_pipe_if
// Bundle of the operand/result signals of the pipelined mALU.
//
// Signals (directions as seen from the ALU, i.e. the slave modport):
//   in_valid   in   operands and opcode valid this cycle
//   ins        in   3-bit opcode
//   A, B       in   WIDTH-bit two's complement operands
//   sticky_clr in   clears the sticky overflow flag
//   out_valid  out  S and flags hold a new result this cycle
//   S          out  WIDTH-bit result
//   Cout       out  carry out of the adder for the result
//   OV         out  signed overflow for the result
//   Z          out  result is zero
//   N          out  result sign bit
//   OV_sticky  out  set by any valid overflowing result
//   acc        out  current accumulator value
//
// The master modport is used by whatever supplies operands (switches,
// register file, testbench); the slave modport is used by the ALU itself.
// ---------------------------------------------------------------------------
interface malu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [2:0]       ins;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             sticky_clr;

    logic             out_valid;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             OV;
    logic             Z;
    logic             N;
    logic             OV_sticky;
    logic [WIDTH-1:0] acc;

    modport master (
        output in_valid, ins, A, B, sticky_clr,
        input  out_valid, S, Cout, OV, Z, N, OV_sticky, acc
    );

    modport slave (
        input  in_valid, ins, A, B, sticky_clr,
        output out_valid, S, Cout, OV, Z, N, OV_sticky, acc
    );
endinterface

// File: rtl/malu_pipe.sv
// ---------------------------------------------------------------------------
// malu_pipe
// Two-stage pipelined N-bit ALU with an internal accumulator and Z/N/sticky
// overflow status. Accepts one operation per clock, never stalls.
//
// Ports:
//   clk  in   system clock, all state updates on the rising edge
//   rst  in   asynchronous, active-high reset
//   bus  slave modport of malu_pipe_if (operands, opcode, handshake, result,
//        flags and accumulator value)
//
// Stage 1 captures opcode/operands when in_valid is high. Stage 2 computes
// from the stage-1 registers and registers the result, flags and
// accumulator, so a result appears two edges after its operands were
// launched.
//
// Opcodes:
//   000 ADD      S = A + B
//   001 SUB      S = A + ~B + 1   (Cout = 1 means no borrow)
//   010 AND      011 OR      100 XOR
//   101 ACC_ADD  S = acc + A, acc <= S
//   110 ACC_LOAD S = A,       acc <= A
//   111 SLT      S = (A < B signed) ? 1 : 0
// ---------------------------------------------------------------------------
module malu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    malu_pipe_if.slave bus
);

    typedef enum logic [2:0] {
        OP_ADD      = 3'b000,
        OP_SUB      = 3'b001,
        OP_AND      = 3'b010,
        OP_OR       = 3'b011,
        OP_XOR      = 3'b100,
        OP_ACC_ADD  = 3'b101,
        OP_ACC_LOAD = 3'b110,
        OP_SLT      = 3'b111
    } opcode_e;

    // Stage 1 registers
    logic             s1Valid_q;
    opcode_e          s1Op_q;
    logic [WIDTH-1:0] s1A_q;
    logic [WIDTH-1:0] s1B_q;

    // Stage 2 (output) registers
    logic             outValid_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ov_q;
    logic             z_q;
    logic             n_q;
    logic             sticky_q;
    logic [WIDTH-1:0] acc_q;

    // Stage 2 next-state values
    logic [WIDTH-1:0] result_d;
    logic             cout_d;
    logic             ov_d;
    logic [WIDTH-1:0] acc_d;
    logic             sticky_d;

    // Shared adder operands and outputs
    logic [WIDTH-1:0] addA;
    logic [WIDTH-1:0] addB;
    logic             carryIn;
    logic [WIDTH:0]   sum;
    logic             addOv;

    // Stage 1: the valid bit follows in_valid every cycle, while the payload
    // is only captured for valid inputs so idle cycles leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            s1Op_q    <= OP_ADD;
            s1A_q     <= '0;
            s1B_q     <= '0;
        end else begin
            s1Valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1Op_q <= opcode_e'(bus.ins);
                s1A_q  <= bus.A;
                s1B_q  <= bus.B;
            end
        end
    end

    // One WIDTH+1 bit adder serves ADD, SUB and ACC_ADD. SUB is done as
    // A + ~B + 1; ACC_ADD feeds the live accumulator in place of A so that
    // back-to-back accumulator ops see the value written one edge earlier.
    always_comb begin
        addA    = s1A_q;
        addB    = s1B_q;
        carryIn = 1'b0;
        case (s1Op_q)
            OP_SUB: begin
                addB    = ~s1B_q;
                carryIn = 1'b1;
            end
            OP_ACC_ADD: begin
                addA = acc_q;
                addB = s1A_q;
            end
            default: ;
        endcase
    end

    assign sum = {1'b0, addA} + {1'b0, addB} + (WIDTH+1)'(carryIn);

    // Same-sign operands producing a different-sign sum. With addB already
    // inverted for SUB this is the usual subtract overflow rule.
    assign addOv = (addA[WIDTH-1] == addB[WIDTH-1]) &&
                   (sum[WIDTH-1] != addA[WIDTH-1]);

    // Result, carry, overflow and accumulator selection for stage 2.
    always_comb begin
        result_d = sum[WIDTH-1:0];
        cout_d   = 1'b0;
        ov_d     = 1'b0;
        acc_d    = acc_q;
        case (s1Op_q)
            OP_ADD, OP_SUB: begin
                cout_d = sum[WIDTH];
                ov_d   = addOv;
            end
            OP_AND: result_d = s1A_q & s1B_q;
            OP_OR:  result_d = s1A_q | s1B_q;
            OP_XOR: result_d = s1A_q ^ s1B_q;
            OP_ACC_ADD: begin
                cout_d = sum[WIDTH];
                ov_d   = addOv;
                acc_d  = sum[WIDTH-1:0];
            end
            OP_ACC_LOAD: begin
                result_d = s1A_q;
                acc_d    = s1A_q;
            end
            OP_SLT: begin
                result_d = {{(WIDTH-1){1'b0}}, ($signed(s1A_q) < $signed(s1B_q))};
            end
            default: ;
        endcase
    end

    // Sticky overflow: a valid overflowing result sets it, and that set takes
    // priority over a clear request arriving on the same edge.
    always_comb begin
        sticky_d = sticky_q;
        if (s1Valid_q && ov_d) begin
            sticky_d = 1'b1;
        end else if (bus.sticky_clr) begin
            sticky_d = 1'b0;
        end
    end

    // Stage 2: everything except out_valid and the sticky flag holds while
    // no valid operation is in stage 1. Z and N are registered alongside S
    // so that they read 0 after reset rather than reflecting S == 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid_q <= 1'b0;
            s_q        <= '0;
            cout_q     <= 1'b0;
            ov_q       <= 1'b0;
            z_q        <= 1'b0;
            n_q        <= 1'b0;
            sticky_q   <= 1'b0;
            acc_q      <= '0;
        end else begin
            outValid_q <= s1Valid_q;
            sticky_q   <= sticky_d;
            if (s1Valid_q) begin
                s_q    <= result_d;
                cout_q <= cout_d;
                ov_q   <= ov_d;
                z_q    <= (result_d == '0);
                n_q    <= result_d[WIDTH-1];
                acc_q  <= acc_d;
            end
        end
    end

    assign bus.out_valid = outValid_q;
    assign bus.S         = s_q;
    assign bus.Cout      = cout_q;
    assign bus.OV        = ov_q;
    assign bus.Z         = z_q;
    assign bus.N         = n_q;
    assign bus.OV_sticky = sticky_q;
    assign bus.acc       = acc_q;

endmodule

// File: tb/tb_malu_pipe.sv
// ---------------------------------------------------------------------------
// tb_malu_pipe
// Directed bench for malu_pipe: one 8-bit instance and one 3-bit instance
// share clock and reset. Inputs are launched 1 time unit after a rising
// edge and outputs are read 1 time unit after a rising edge, so operands
// launched after edge k are captured at k+1 and appear after edge k+2.
// ---------------------------------------------------------------------------
module tb_malu_pipe;

    localparam logic [2:0] ADD      = 3'b000;
    localparam logic [2:0] SUB      = 3'b001;
    localparam logic [2:0] AND_OP   = 3'b010;
    localparam logic [2:0] ACC_ADD  = 3'b101;
    localparam logic [2:0] ACC_LOAD = 3'b110;
    localparam logic [2:0] SLT      = 3'b111;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    malu_pipe_if #(.WIDTH(8)) bus8 ();
    malu_pipe_if #(.WIDTH(3)) bus3 ();

    malu_pipe #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    malu_pipe #(.WIDTH(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the 8-bit instance inputs.
    task automatic applyStimulus(input logic v, input logic [2:0] op,
                                 input logic [7:0] a, input logic [7:0] b,
                                 input logic clr);
        bus8.in_valid   = v;
        bus8.ins        = op;
        bus8.A          = a;
        bus8.B          = b;
        bus8.sticky_clr = clr;
    endtask

    // Drive the 3-bit instance inputs.
    task automatic applyStimulus3(input logic v, input logic [2:0] op,
                                  input logic [2:0] a, input logic [2:0] b);
        bus3.in_valid   = v;
        bus3.ins        = op;
        bus3.A          = a;
        bus3.B          = b;
        bus3.sticky_clr = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        applyStimulus(1'b0, ADD, 8'h00, 8'h00, 1'b0);
        applyStimulus3(1'b0, ADD, 3'd0, 3'd0);

        // Reset state
        tick();
        tick();
        checkOutput("rst_out_valid", 32'(bus8.out_valid), 32'h0);
        checkOutput("rst_S",         32'(bus8.S),         32'h0);
        checkOutput("rst_Z",         32'(bus8.Z),         32'h0);
        checkOutput("rst_acc",       32'(bus8.acc),       32'h0);
        checkOutput("rst_sticky",    32'(bus8.OV_sticky), 32'h0);
        rst = 1'b0;
        tick();

        // ADD 0x7F + 0x01: out_valid only after the second edge
        applyStimulus(1'b1, ADD, 8'h7F, 8'h01, 1'b0);
        tick();
        applyStimulus(1'b0, ADD, 8'h00, 8'h00, 1'b0);
        checkOutput("add_lat_early", 32'(bus8.out_valid), 32'h0);
        tick();
        checkOutput("add_valid",  32'(bus8.out_valid), 32'h1);
        checkOutput("add_S",      32'(bus8.S),         32'h80);
        checkOutput("add_OV",     32'(bus8.OV),        32'h1);
        checkOutput("add_Cout",   32'(bus8.Cout),      32'h0);
        checkOutput("add_N",      32'(bus8.N),         32'h1);
        checkOutput("add_Z",      32'(bus8.Z),         32'h0);
        checkOutput("add_sticky", 32'(bus8.OV_sticky), 32'h1);
        tick();
        checkOutput("add_valid_drop", 32'(bus8.out_valid), 32'h0);
        checkOutput("add_S_hold",     32'(bus8.S),         32'h80);

        // Clear sticky with nothing in flight
        applyStimulus(1'b0, ADD, 8'h00, 8'h00, 1'b1);
        tick();
        checkOutput("clr_sticky", 32'(bus8.OV_sticky), 32'h0);

        // SUB 5-7 then SUB 7-7 back to back
        applyStimulus(1'b1, SUB, 8'h05, 8'h07, 1'b0);
        tick();
        applyStimulus(1'b1, SUB, 8'h07, 8'h07, 1'b0);
        tick();
        applyStimulus(1'b0, ADD, 8'h00, 8'h00, 1'b0);
        checkOutput("sub1_valid", 32'(bus8.out_valid), 32'h1);
        checkOutput("sub1_S",     32'(bus8.S),         32'hFE);
        checkOutput("sub1_Cout",  32'(bus8.Cout),      32'h0);
        checkOutput("sub1_OV",    32'(bus8.OV),        32'h0);
        checkOutput("sub1_N",     32'(bus8.N),         32'h1);
        tick();
        checkOutput("sub2_valid", 32'(bus8.out_valid), 32'h1);
        checkOutput("sub2_S",     32'(bus8.S),         32'h00);
        checkOutput("sub2_Z",     32'(bus8.Z),         32'h1);
        checkOutput("sub2_Cout",  32'(bus8.Cout),      32'h1);

        // Accumulator chain: LOAD 0x10, ADD 0x05, ADD 0xF0
        applyStimulus(1'b1, ACC_LOAD, 8'h10, 8'h00, 1'b0);
        tick();
        applyStimulus(1'b1, ACC_ADD, 8'h05, 8'h00, 1'b0);
        tick();
        applyStimulus(1'b1, ACC_ADD, 8'hF0, 8'h00, 1'b0);
        checkOutput("accld_S",   32'(bus8.S),   32'h10);
        checkOutput("accld_acc", 32'(bus8.acc), 32'h10);
        tick();
        applyStimulus(1'b0, ADD, 8'h00, 8'h00, 1'b0);
        checkOutput("acc1_valid", 32'(bus8.out_valid), 32'h1);
        checkOutput("acc1_S",     32'(bus8.S),         32'h15);
        checkOutput("acc1_acc",   32'(bus8.acc),       32'h15);
        tick();
        checkOutput("acc2_S",    32'(bus8.S),    32'h05);
        checkOutput("acc2_Cout", 32'(bus8.Cout), 32'h1);
        checkOutput("acc2_OV",   32'(bus8.OV),   32'h0);
        checkOutput("acc2_acc",  32'(bus8.acc),  32'h05);

        // Sticky set and clear on the same edge: set wins
        applyStimulus(1'b1, ADD, 8'h7F, 8'h01, 1'b0);
        tick();
        applyStimulus(1'b0, ADD, 8'h00, 8'h00, 1'b1);
        tick();
        checkOutput("race_OV",     32'(bus8.OV),        32'h1);
        checkOutput("race_sticky", 32'(bus8.OV_sticky), 32'h1);
        checkOutput("race_acc",    32'(bus8.acc),       32'h05);
        tick();
        applyStimulus(1'b0, ADD, 8'h00, 8'h00, 1'b0);
        checkOutput("late_clr_sticky", 32'(bus8.OV_sticky), 32'h0);

        // WIDTH=3: ADD 3+2, AND 3&2, SLT -2<1
        applyStimulus3(1'b1, ADD, 3'b011, 3'b010);
        tick();
        applyStimulus3(1'b1, AND_OP, 3'b011, 3'b010);
        tick();
        applyStimulus3(1'b1, SLT, 3'b110, 3'b001);
        checkOutput("w3_add_S",    32'(bus3.S),    32'h5);
        checkOutput("w3_add_OV",   32'(bus3.OV),   32'h1);
        checkOutput("w3_add_Cout", 32'(bus3.Cout), 32'h0);
        tick();
        applyStimulus3(1'b0, ADD, 3'd0, 3'd0);
        checkOutput("w3_and_S",  32'(bus3.S),  32'h2);
        checkOutput("w3_and_OV", 32'(bus3.OV), 32'h0);
        tick();
        checkOutput("w3_slt_S",     32'(bus3.S),         32'h1);
        checkOutput("w3_sticky",    32'(bus3.OV_sticky), 32'h1);

        // Reset with operations in flight
        applyStimulus(1'b1, ADD, 8'h01, 8'h02, 1'b0);
        tick();
        applyStimulus(1'b1, ADD, 8'h03, 8'h04, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        applyStimulus(1'b0, ADD, 8'h00, 8'h00, 1'b0);
        checkOutput("mid_rst_S",     32'(bus8.S),         32'h0);
        checkOutput("mid_rst_acc",   32'(bus8.acc),       32'h0);
        checkOutput("mid_rst_N",     32'(bus8.N),         32'h0);
        checkOutput("mid_rst_OV",    32'(bus8.OV),        32'h0);
        checkOutput("mid_rst_w3_S",  32'(bus3.S),         32'h0);
        checkOutput("mid_rst_w3_stk", 32'(bus3.OV_sticky), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("post_rst_valid1", 32'(bus8.out_valid), 32'h0);
        tick();
        checkOutput("post_rst_valid2", 32'(bus8.out_valid), 32'h0);

        // ACC_ADD 1 after reset
        applyStimulus(1'b1, ACC_ADD, 8'h01, 8'h00, 1'b0);
        tick();
        applyStimulus(1'b0, ADD, 8'h00, 8'h00, 1'b0);
        tick();
        checkOutput("post_rst_acc_valid", 32'(bus8.out_valid), 32'h1);
        checkOutput("post_rst_acc_S",     32'(bus8.S),         32'h01);
        checkOutput("post_rst_acc_acc",   32'(bus8.acc),       32'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
